// File: rtl/reg_file_pkg.sv
// Shared constants and types for the multi-port register file and its scoreboard.
// Default geometry matches the 16x32 core register file with 3 read and 2 write ports.
package reg_file_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_DEPTH  = 16;
  localparam int DEFAULT_NUM_RD = 3;
  localparam int DEFAULT_NUM_WR = 2;
  localparam int DEFAULT_ADDR_W = $clog2(DEFAULT_DEPTH);

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEFAULT_WIDTH-1:0]  reg_data_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle between the pipeline and reg_file_mp.
// The pipeline side (master) drives writes, reads and reservations.
// The register file side (slave) returns read data and scoreboard state.
interface reg_file_mp_if #(
  parameter int WIDTH  = reg_file_pkg::DEFAULT_WIDTH,
  parameter int DEPTH  = reg_file_pkg::DEFAULT_DEPTH,
  parameter int NUM_RD = reg_file_pkg::DEFAULT_NUM_RD,
  parameter int NUM_WR = reg_file_pkg::DEFAULT_NUM_WR
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [NUM_WR-1:0]             wr_en;
  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr;
  logic [NUM_WR-1:0][WIDTH-1:0]  wr_data;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][WIDTH-1:0]  rd_data;
  logic                          rsv_en;
  logic [ADDR_W-1:0]             rsv_addr;
  logic [NUM_RD-1:0]             rd_busy;
  logic [DEPTH-1:0]              busy_vec;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_vec
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard used by the hazard unit.
// A write to a register clears its busy bit, a reservation sets it,
// and a reservation wins over a write to the same register in the same cycle
// because the newly issued producer is still in flight.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int  DEPTH  = DEFAULT_DEPTH,
  parameter int  NUM_WR = DEFAULT_NUM_WR,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr,
  input  logic                          rsv_en,
  input  logic [ADDR_W-1:0]             rsv_addr,
  output logic [DEPTH-1:0]              busy_vec
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_clrVec;
  logic [DEPTH-1:0] w_setVec;
  logic [DEPTH-1:0] w_busyNext;

  // Decode write ports into clear requests and the reservation into a set request; set dominates.
  always_comb begin
    w_clrVec = '0;
    w_setVec = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i]) begin
        w_clrVec[wr_addr[i]] = 1'b1;
      end
    end
    if (rsv_en) begin
      w_setVec[rsv_addr] = 1'b1;
    end
    w_busyNext = w_setVec | (r_busy & ~w_clrVec);
  end

  // Scoreboard state; reset overrides any write or reservation in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busyNext;
    end
  end

  assign busy_vec = r_busy;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with busy scoreboard.
// NUM_WR write ports (highest index wins on an address conflict), NUM_RD
// combinational read ports, synchronous clear, and per-register busy flags.
// Optional feature macro: REG_FILE_BYPASS_EN enables write-to-read forwarding
// of data and of the busy clear; without it reads see registered state only.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int  WIDTH  = DEFAULT_WIDTH,
  parameter int  DEPTH  = DEFAULT_DEPTH,
  parameter int  NUM_RD = DEFAULT_NUM_RD,
  parameter int  NUM_WR = DEFAULT_NUM_WR,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           reset,
  reg_file_mp_if.slave  bus
);

  logic [WIDTH-1:0]             r_mem [DEPTH];
  logic [DEPTH-1:0]             w_busyVec;
  logic [NUM_RD-1:0][WIDTH-1:0] w_rdData;
  logic [NUM_RD-1:0]            w_rdBusy;

  // Storage update; later ports overwrite earlier ones so the highest index wins a conflict.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < DEPTH; d++) begin
        r_mem[d] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (bus.wr_en[i]) begin
          r_mem[bus.wr_addr[i]] <= bus.wr_data[i];
        end
      end
    end
  end

  // Read muxes for data and busy flags, with optional same-cycle forwarding from the write ports.
  always_comb begin
    w_rdData = '0;
    w_rdBusy = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      w_rdData[j] = r_mem[bus.rd_addr[j]];
      w_rdBusy[j] = w_busyVec[bus.rd_addr[j]];
`ifdef REG_FILE_BYPASS_EN
      for (int i = 0; i < NUM_WR; i++) begin
        if (bus.wr_en[i] && (bus.wr_addr[i] == bus.rd_addr[j])) begin
          w_rdData[j] = bus.wr_data[i];
          if (!(bus.rsv_en && (bus.rsv_addr == bus.rd_addr[j]))) begin
            w_rdBusy[j] = 1'b0;
          end
        end
      end
`endif
    end
  end

  reg_scoreboard #(
    .DEPTH  (DEPTH),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .busy_vec (w_busyVec)
  );

  assign bus.rd_data  = w_rdData;
  assign bus.rd_busy  = w_rdBusy;
  assign bus.busy_vec = w_busyVec;

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp: directed vector table for the documented
// scenarios, then random traffic checked against an array-based reference model.
// Honours REG_FILE_BYPASS_EN so the same bench covers both builds.
module tb_reg_file_mp;
  import reg_file_pkg::*;

  localparam int NUM_RD = DEFAULT_NUM_RD;
  localparam int NUM_WR = DEFAULT_NUM_WR;
  localparam int DEPTH  = DEFAULT_DEPTH;

  typedef struct {
    logic       rst;
    logic [1:0] wrEn;
    reg_addr_t  wa0;
    reg_data_t  wd0;
    reg_addr_t  wa1;
    reg_data_t  wd1;
    logic       rsv;
    reg_addr_t  rsvAddr;
    reg_addr_t  ra0;
    reg_addr_t  ra1;
    reg_addr_t  ra2;
    reg_data_t  e0;
    reg_data_t  e1;
    reg_data_t  e2;
    reg_data_t  b0;
    reg_data_t  b1;
    reg_data_t  b2;
    logic [2:0] eBusy;
    logic [2:0] bBusy;
    logic [15:0] eVec;
  } vec_t;

  logic clk;
  logic reset;
  int   vecCount;
  int   missCount;

  reg_data_t   refMem [DEPTH];
  logic [15:0] refBusy;

  reg_file_mp_if bus ();

  reg_file_mp dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(
    logic rst, logic [1:0] wrEn,
    reg_addr_t wa0, reg_data_t wd0, reg_addr_t wa1, reg_data_t wd1,
    logic rsv, reg_addr_t rsvAddr,
    reg_addr_t ra0, reg_addr_t ra1, reg_addr_t ra2,
    reg_data_t e0, reg_data_t e1, reg_data_t e2,
    reg_data_t b0, reg_data_t b1, reg_data_t b2,
    logic [2:0] eBusy, logic [2:0] bBusy, logic [15:0] eVec);
    vec_t v;
    v.rst = rst; v.wrEn = wrEn;
    v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.rsv = rsv; v.rsvAddr = rsvAddr;
    v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2;
    v.e0 = e0; v.e1 = e1; v.e2 = e2;
    v.b0 = b0; v.b1 = b1; v.b2 = b2;
    v.eBusy = eBusy; v.bBusy = bBusy; v.eVec = eVec;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(
    input logic rst, input logic [1:0] wrEn,
    input reg_addr_t wa0, input reg_data_t wd0,
    input reg_addr_t wa1, input reg_data_t wd1,
    input logic rsv, input reg_addr_t rsvAddr,
    input reg_addr_t ra0, input reg_addr_t ra1, input reg_addr_t ra2);
    reset          = rst;
    bus.wr_en      = wrEn;
    bus.wr_addr[0] = wa0;
    bus.wr_data[0] = wd0;
    bus.wr_addr[1] = wa1;
    bus.wr_data[1] = wd1;
    bus.rsv_en     = rsv;
    bus.rsv_addr   = rsvAddr;
    bus.rd_addr[0] = ra0;
    bus.rd_addr[1] = ra1;
    bus.rd_addr[2] = ra2;
    #1;
  endtask

  // Reference model: what a register read returns this cycle.
  function automatic reg_data_t modelRead(reg_addr_t a);
    reg_data_t d;
    d = refMem[a];
`ifdef REG_FILE_BYPASS_EN
    for (int i = 0; i < NUM_WR; i++) begin
      if (bus.wr_en[i] && bus.wr_addr[i] == a) d = bus.wr_data[i];
    end
`endif
    return d;
  endfunction

  // Reference model: busy flag seen by a read port this cycle.
  function automatic logic modelBusy(reg_addr_t a);
    logic b;
    b = refBusy[a];
`ifdef REG_FILE_BYPASS_EN
    for (int i = 0; i < NUM_WR; i++) begin
      if (bus.wr_en[i] && bus.wr_addr[i] == a && !(bus.rsv_en && bus.rsv_addr == a)) b = 1'b0;
    end
`endif
    return b;
  endfunction

  // Reference model: commit one clock edge using the stimulus currently driven.
  task automatic modelStep();
    reg_addr_t written[$];
    if (reset) begin
      foreach (refMem[k]) refMem[k] = '0;
      refBusy = '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (bus.wr_en[i]) begin
          refMem[bus.wr_addr[i]] = bus.wr_data[i];
          written.push_back(bus.wr_addr[i]);
        end
      end
      foreach (written[k]) refBusy[written[k]] = 1'b0;
      if (bus.rsv_en) refBusy[bus.rsv_addr] = 1'b1;
    end
  endtask

  task automatic finishCycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic checkAgainstModel(input int cyc);
    for (int j = 0; j < NUM_RD; j++) begin
      checkOutput($sformatf("rand c%0d rd_data%0d", cyc, j), bus.rd_data[j], modelRead(bus.rd_addr[j]));
      checkOutput($sformatf("rand c%0d rd_busy%0d", cyc, j), 32'(bus.rd_busy[j]), 32'(modelBusy(bus.rd_addr[j])));
    end
    checkOutput($sformatf("rand c%0d busy_vec", cyc), 32'(bus.busy_vec), 32'(refBusy));
  endtask

  vec_t table_q [$];

  initial begin
    vecCount  = 0;
    missCount = 0;
    refBusy   = '0;

    table_q.push_back(mkVec(0, 2'b01, 4'd3, 32'hDEADBEEF, 4'd0, 32'h0, 0, 4'd0, 4'd3, 4'd3, 4'd3,
      32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 3'b000, 16'h0000));
    table_q.push_back(mkVec(0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 0, 4'd0, 4'd3, 4'd0, 4'd5,
      32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 3'b000, 3'b000, 16'h0000));
    table_q.push_back(mkVec(0, 2'b11, 4'd5, 32'h11111111, 4'd5, 32'h22222222, 0, 4'd0, 4'd5, 4'd5, 4'd5,
      32'h0, 32'h0, 32'h0, 32'h22222222, 32'h22222222, 32'h22222222, 3'b000, 3'b000, 16'h0000));
    table_q.push_back(mkVec(0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 0, 4'd0, 4'd5, 4'd5, 4'd5,
      32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222, 3'b000, 3'b000, 16'h0000));
    table_q.push_back(mkVec(0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1, 4'd7, 4'd7, 4'd3, 4'd5,
      32'h0, 32'hDEADBEEF, 32'h22222222, 32'h0, 32'hDEADBEEF, 32'h22222222, 3'b000, 3'b000, 16'h0000));
    table_q.push_back(mkVec(0, 2'b01, 4'd7, 32'hA5A5A5A5, 4'd0, 32'h0, 0, 4'd0, 4'd7, 4'd3, 4'd5,
      32'h0, 32'hDEADBEEF, 32'h22222222, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h22222222, 3'b001, 3'b000, 16'h0080));
    table_q.push_back(mkVec(0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 0, 4'd0, 4'd7, 4'd3, 4'd5,
      32'hA5A5A5A5, 32'hDEADBEEF, 32'h22222222, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h22222222, 3'b000, 3'b000, 16'h0000));
    table_q.push_back(mkVec(0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1, 4'd9, 4'd9, 4'd7, 4'd3,
      32'h0, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h0, 32'hA5A5A5A5, 32'hDEADBEEF, 3'b000, 3'b000, 16'h0000));
    table_q.push_back(mkVec(0, 2'b10, 4'd0, 32'h0, 4'd9, 32'h99990000, 1, 4'd9, 4'd9, 4'd9, 4'd7,
      32'h0, 32'h0, 32'hA5A5A5A5, 32'h99990000, 32'h99990000, 32'hA5A5A5A5, 3'b011, 3'b011, 16'h0200));
    table_q.push_back(mkVec(0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 0, 4'd0, 4'd9, 4'd2, 4'd15,
      32'h99990000, 32'h0, 32'h0, 32'h99990000, 32'h0, 32'h0, 3'b001, 3'b001, 16'h0200));
    table_q.push_back(mkVec(0, 2'b01, 4'd15, 32'hFFFFFFFF, 4'd0, 32'h0, 1, 4'd2, 4'd15, 4'd2, 4'd9,
      32'h0, 32'h0, 32'h99990000, 32'hFFFFFFFF, 32'h0, 32'h99990000, 3'b100, 3'b100, 16'h0200));
    table_q.push_back(mkVec(1, 2'b01, 4'd4, 32'h12345678, 4'd0, 32'h0, 0, 4'd0, 4'd15, 4'd2, 4'd4,
      32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h12345678, 3'b010, 3'b010, 16'h0204));
    table_q.push_back(mkVec(0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 0, 4'd0, 4'd15, 4'd2, 4'd4,
      32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 16'h0000));

    applyStimulus(1, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    finishCycle();
    finishCycle();

    // Out of reset every address reads zero and nothing is busy.
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 0, 4'd0, reg_addr_t'(a), reg_addr_t'(a), reg_addr_t'(a));
      for (int j = 0; j < NUM_RD; j++) begin
        checkOutput($sformatf("reset addr%0d rd_data%0d", a, j), bus.rd_data[j], 32'h0);
      end
      checkOutput($sformatf("reset addr%0d rd_busy", a), 32'(bus.rd_busy), 32'h0);
      checkOutput($sformatf("reset addr%0d busy_vec", a), 32'(bus.busy_vec), 32'h0);
    end

    foreach (table_q[k]) begin
      vec_t v;
      reg_data_t x0, x1, x2;
      logic [2:0] xb;
      v = table_q[k];
      applyStimulus(v.rst, v.wrEn, v.wa0, v.wd0, v.wa1, v.wd1, v.rsv, v.rsvAddr, v.ra0, v.ra1, v.ra2);
`ifdef REG_FILE_BYPASS_EN
      x0 = v.b0; x1 = v.b1; x2 = v.b2; xb = v.bBusy;
`else
      x0 = v.e0; x1 = v.e1; x2 = v.e2; xb = v.eBusy;
`endif
      checkOutput($sformatf("vec%0d rd_data0", k), bus.rd_data[0], x0);
      checkOutput($sformatf("vec%0d rd_data1", k), bus.rd_data[1], x1);
      checkOutput($sformatf("vec%0d rd_data2", k), bus.rd_data[2], x2);
      checkOutput($sformatf("vec%0d rd_busy", k), 32'(bus.rd_busy), 32'(xb));
      checkOutput($sformatf("vec%0d busy_vec", k), 32'(bus.busy_vec), 32'(v.eVec));
      finishCycle();
    end

    // Random traffic biased toward address collisions between ports.
    for (int c = 0; c < 400; c++) begin
      logic       rst;
      logic [1:0] wrEn;
      logic       rsv;
      reg_addr_t  wa0, wa1, rsvAddr;
      reg_addr_t  ra [3];
      rst     = ($urandom_range(0, 49) == 0);
      wrEn    = 2'($urandom_range(0, 3));
      rsv     = 1'($urandom_range(0, 1));
      wa0     = reg_addr_t'($urandom_range(0, 15));
      wa1     = ($urandom_range(0, 1) == 1) ? wa0 : reg_addr_t'($urandom_range(0, 15));
      rsvAddr = ($urandom_range(0, 2) == 0) ? wa1 : reg_addr_t'($urandom_range(0, 15));
      for (int j = 0; j < 3; j++) begin
        case ($urandom_range(0, 3))
          0:       ra[j] = wa0;
          1:       ra[j] = wa1;
          2:       ra[j] = rsvAddr;
          default: ra[j] = reg_addr_t'($urandom_range(0, 15));
        endcase
      end
      applyStimulus(rst, wrEn, wa0, reg_data_t'($urandom), wa1, reg_data_t'($urandom),
                    rsv, rsvAddr, ra[0], ra[1], ra[2]);
      checkAgainstModel(c);
      finishCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file; next generation of the 16x32, 2-read/1-write core register file.
- Adds NUM_RD read ports, NUM_WR write ports with fixed priority, synchronous clear, and a per-register busy scoreboard for pipeline hazard detection.
- Sits in the decode/writeback stage of the pipelined core.
- Read data feeds the operand muxes; busy flags feed the hazard unit.

Parameters:
- WIDTH, 32, data bits per register
- DEPTH, 16, number of registers (power of 2, >= 2)
- NUM_RD, 3, read ports
- NUM_WR, 2, write ports; higher index has priority on an address conflict
- ADDR_W, $clog2(DEPTH), derived address width; not overridden

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high; clears registers and busy bits at posedge
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR x ADDR_W  write addresses
- wr_data  in  NUM_WR x WIDTH  write data
- rd_addr  in  NUM_RD x ADDR_W  read addresses
- rd_data  out  NUM_RD x WIDTH  read data, combinational from rd_addr
- rsv_en  in  1  reserve a destination register (instruction issued with a pending write)
- rsv_addr  in  ADDR_W  register to mark busy
- rd_busy  out  NUM_RD  busy flag of the register at each rd_addr, combinational
- busy_vec  out  DEPTH  full scoreboard, registered state

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- On the reset posedge, every register becomes 0 and busy_vec becomes 0. Reset overrides any write or reserve in that cycle.
- After reset, rd_data = 0 for all addresses and rd_busy = 0.
- Write: if wr_en[i] is high at posedge, reg[wr_addr[i]] <= wr_data[i]. Visible on rd_data the cycle after (1-cycle write latency, no bypass by default).
- Write conflict: several enabled ports with the same address. The highest index wins; the lower ports' data is discarded.
- Writes to distinct addresses in the same cycle all commit.
- Read: rd_data[j] = reg[rd_addr[j]] combinationally. It changes in the same cycle rd_addr changes. Reads never alter state.
- Scoreboard, per register r, at each posedge:
  - clear: any enabled write port targets r -> busy[r] <= 0
  - set: rsv_en high and rsv_addr == r -> busy[r] <= 1
  - set wins over clear on the same address in the same cycle (the new producer is still in flight)
  - otherwise busy[r] holds
- Reserving an already-busy register leaves it busy; there is no counting.
- Writing a non-busy register is legal and leaves busy at 0.
- rd_busy[j] = busy_vec[rd_addr[j]]. It reflects registered state, so same-cycle writes and reserves are not seen.
- No register is hardwired. PC handling stays outside this block.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN
- Defined: write-to-read forwarding.
  - If any wr_en[i] is high and wr_addr[i] == rd_addr[j], rd_data[j] returns that wr_data in the same cycle, using the same highest-index priority.
  - rd_busy[j] is also forced to 0 when a write clears that address, unless a same-cycle reserve to that address is active.
- Undefined: pure registered read path as described under Behaviour; new data appears one cycle after the write.

Decomposition:
- Package reg_file_pkg holds:
  - default WIDTH/DEPTH constants
  - typedef reg_addr_t (logic [ADDR_W-1:0] for the default depth)
  - typedef reg_data_t
- One sub-module, reg_scoreboard:
  - owns busy_vec and the set/clear priority logic
  - takes wr_en, wr_addr, rsv_en, rsv_addr, clk, reset
- The storage array and read muxes stay in reg_file_mp.

Test Plan:
- Reset, then read all 16 addresses -> rd_data = 0x00000000 and busy_vec = 0x0000.
- wr_en[0]=1, wr_addr[0]=3, wr_data[0]=0xDEADBEEF; rd_addr[0]=3 -> rd_data[0] shows the old 0 that cycle and 0xDEADBEEF the next.
  - With REG_FILE_BYPASS_EN: 0xDEADBEEF in the same cycle.
- Both ports write address 5, with port0 = 0x11111111 and port1 = 0x22222222 -> next cycle reg5 = 0x22222222. Also read reg5 on all 3 ports simultaneously, all equal.
- rsv_en=1, rsv_addr=7 -> busy_vec[7]=1 next cycle. Then write reg7 -> busy_vec[7]=0 the following cycle.
- Same cycle: rsv_addr=9 and wr_addr[1]=9 with reg9 busy -> busy_vec[9] stays 1 and reg9 is updated.
- Write 0xFFFFFFFF to reg15 and reserve reg2, then assert reset mid-sequence together with a write to reg4 -> next cycle all registers 0, busy_vec = 0, and reg4 = 0.
